// File: rtl/prim_unpacker.sv
// Purpose: split wide LSB-packed masked words into narrow masked beats, passing last through.
// Latency: word accepted at edge N gives its first beat from cycle N+1, then one beat per cycle.
// Backpressure: beats hold until ready_i; ready_o reopens in the cycle the final beat drains.
module prim_unpacker #(
    parameter int InW  = 64,
    parameter int OutW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            valid_i,
    input  logic [InW-1:0]  data_i,
    input  logic [InW-1:0]  mask_i,
    input  logic            last_i,
    output logic            ready_o,

    output logic            valid_o,
    output logic [OutW-1:0] data_o,
    output logic [OutW-1:0] mask_o,
    output logic            last_o,
    input  logic            ready_i,

    input  logic            flush_i,
    output logic            flush_done_o,
    output logic            err_o
);

    localparam int RW = $clog2(InW + 1);
    localparam logic [RW-1:0]  OutWR  = RW'(OutW);
    localparam logic [InW-1:0] InOne  = InW'(1);

    // Remaining data (right-aligned) and its valid bit count.
    logic [InW-1:0] buf_q;
    logic [RW-1:0]  rem_q;
    logic           last_q;
    // A zero-mask word with last_i still owes one empty last beat.
    logic           zlast_q;
    logic           flush_q;

    logic [RW-1:0]  in_cnt;
    logic [InW-1:0] mask_inc;
    logic           mask_hole;
    logic           empty;
    logic           final_beat;
    logic           ack_in;
    logic           ack_out;

    // Count of accepted bits: highest set mask bit plus one, holes included.
    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < InW; i++) begin
            if (mask_i[i]) begin
                in_cnt = RW'(i + 1);
            end
        end
    end

    // A mask contiguous from bit 0 has no bit in common with itself plus one.
    always_comb begin
        mask_inc  = mask_i + InOne;
        mask_hole = |(mask_i & mask_inc);
    end

    // Handshake and flow-control decode.
    always_comb begin
        empty      = (rem_q == '0) && !zlast_q;
        final_beat = (rem_q <= OutWR);
        valid_o    = (rem_q != '0) || zlast_q;
        ack_out    = valid_o && ready_i;
        // Reopen in the draining cycle so back-to-back words see no bubble.
        ready_o    = !flush_i && !flush_q &&
                     (empty || (ack_out && final_beat && !zlast_q));
        ack_in     = valid_i && ready_o;
        err_o      = ack_in && mask_hole;
    end

    // Beat view of the buffer: low min(rem_q, OutW) bits are valid.
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < OutW; i++) begin
            mask_o[i] = (RW'(i) < rem_q);
        end
        data_o       = buf_q[OutW-1:0] & mask_o;
        last_o       = (valid_o && last_q && final_beat) || zlast_q;
        flush_done_o = flush_q;
    end

    // State update: reset, then flush, then load (wins over a draining beat), then shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            zlast_q <= 1'b0;
            flush_q <= 1'b0;
        end else if (flush_i) begin
            buf_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            zlast_q <= 1'b0;
            flush_q <= 1'b1;
        end else begin
            flush_q <= 1'b0;
            if (ack_in) begin
                buf_q   <= data_i & mask_i;
                rem_q   <= in_cnt;
                last_q  <= last_i;
                zlast_q <= (mask_i == '0) && last_i;
            end else if (ack_out) begin
                buf_q   <= buf_q >> OutW;
                rem_q   <= final_beat ? '0 : (rem_q - OutWR);
                zlast_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prim_unpacker.sv
// Purpose: directed checks of beat splitting, masks, last, errors, flush and reset.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Backpressure: ready_i held high or toggled per cycle in the streaming runs.
module tb_prim_unpacker;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [63:0] data_i = '0;
    logic [63:0] mask_i = '0;
    logic        last_i = 1'b0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic [31:0] mask_o;
    logic        last_o;
    logic        ready_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        flush_done_o;
    logic        err_o;

    int n_chk  = 0;
    int n_fail = 0;

    prim_unpacker #(.InW(64), .OutW(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .mask_i       (mask_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .mask_o       (mask_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one word, confirm it is taken this cycle, then withdraw it.
    task automatic accept(input logic [63:0] d, input logic [63:0] m, input logic l, input logic e);
        valid_i = 1'b1;
        data_i  = d;
        mask_i  = m;
        last_i  = l;
        #1;
        check("acc_rdy", ready_o, 1);
        check("acc_err", err_o, e);
        tick();
        valid_i = 1'b0;
        data_i  = '0;
        mask_i  = '0;
        last_i  = 1'b0;
    endtask

    // Three full words with last set; beat k carries 0x10000001+k, odd beats are last.
    task automatic run_stream(input bit toggle);
        int wi = 0;
        int bi = 0;
        int first_c = -1;
        int last_c = -1;
        logic pstall = 1'b0;
        logic [31:0] pdat = '0;
        for (int c = 0; c < 40 && bi < 6; c++) begin
            valid_i = (wi < 3);
            data_i  = {32'(32'h10000002 + 2 * wi), 32'(32'h10000001 + 2 * wi)};
            mask_i  = (wi < 3) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
            last_i  = 1'b1;
            ready_i = toggle ? (c % 2 == 1) : 1'b1;
            #1;
            if (pstall) begin
                check("hold_vld", valid_o, 1);
                check("hold_dat", data_o, pdat);
            end
            if (valid_o && ready_i) begin
                check("beat_dat", data_o, 32'h10000001 + bi);
                check("beat_last", last_o, bi % 2);
                if (first_c < 0) first_c = c;
                last_c = c;
                bi++;
            end
            pstall = valid_o && !ready_i;
            pdat   = data_o;
            if (valid_i && ready_o) wi++;
            tick();
        end
        valid_i = 1'b0;
        mask_i  = '0;
        data_i  = '0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        check("beat_cnt", bi, 6);
        if (!toggle) check("no_gap", last_c - first_c, 5);
        #1;
        check("drained", valid_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_vld", valid_o, 0);
        check("rst_dat", data_o, 0);
        check("rst_msk", mask_o, 0);
        check("rst_last", last_o, 0);
        check("rst_fdone", flush_done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rdy", ready_o, 1);

        // Full 64-bit word into two beats
        accept(64'h1122334455667788, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        #1;
        check("w1_vld0", valid_o, 1);
        check("w1_dat0", data_o, 32'h55667788);
        check("w1_msk0", mask_o, 32'hFFFFFFFF);
        check("w1_last0", last_o, 0);
        check("w1_rdy0", ready_o, 0);
        tick();
        #1;
        check("w1_dat1", data_o, 32'h11223344);
        check("w1_msk1", mask_o, 32'hFFFFFFFF);
        check("w1_last1", last_o, 1);
        check("w1_rdy1", ready_o, 1);
        tick();
        #1;
        check("w1_idle", valid_o, 0);

        // 40-bit mask: full beat then 8-bit partial beat
        accept(64'hAABBCCDDEEFF0011, 64'h0000_00FF_FFFF_FFFF, 1'b0, 1'b0);
        #1;
        check("p_dat0", data_o, 32'hEEFF0011);
        check("p_msk0", mask_o, 32'hFFFFFFFF);
        tick();
        #1;
        check("p_dat1", data_o, 32'h000000DD);
        check("p_msk1", mask_o, 32'h000000FF);
        check("p_last1", last_o, 0);
        tick();
        #1;
        check("p_idle", valid_o, 0);

        // Streaming, free-running then stalled every other cycle
        run_stream(1'b0);
        run_stream(1'b1);

        // Zero-mask words
        accept(64'h1234, 64'h0, 1'b0, 1'b0);
        #1;
        check("z0_vld", valid_o, 0);
        check("z0_rdy", ready_o, 1);
        accept(64'h5678, 64'h0, 1'b1, 1'b0);
        #1;
        check("z1_vld", valid_o, 1);
        check("z1_msk", mask_o, 0);
        check("z1_dat", data_o, 0);
        check("z1_last", last_o, 1);
        tick();
        #1;
        check("z1_idle", valid_o, 0);

        // Non-contiguous mask flags an error and still counts the holes as width
        accept(64'h123456789ABCDEFF, 64'h00000000_000000F5, 1'b1, 1'b1);
        #1;
        check("e_err_clr", err_o, 0);
        check("e_msk", mask_o, 32'h000000FF);
        check("e_dat", data_o, 32'h000000F5);
        check("e_last", last_o, 1);
        tick();

        // Flush after the first beat of a two-beat word
        accept(64'hCAFEF00D_DEADBEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        #1;
        check("f_dat0", data_o, 32'hDEADBEEF);
        tick();
        flush_i = 1'b1;
        ready_i = 1'b0;
        #1;
        check("f_vld_hold", valid_o, 1);
        check("f_rdy_blk", ready_o, 0);
        tick();
        flush_i = 1'b0;
        #1;
        check("f_done", flush_done_o, 1);
        check("f_vld", valid_o, 0);
        tick();
        #1;
        check("f_done_clr", flush_done_o, 0);
        check("f_rdy", ready_o, 1);
        check("f_vld2", valid_o, 0);
        ready_i = 1'b1;

        // Reset in the middle of a word
        accept(64'h0102030405060708, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        ready_i = 1'b0;
        rst_i   = 1'b1;
        #1;
        check("r_pre_vld", valid_o, 1);
        tick();
        rst_i = 1'b0;
        #1;
        check("r_vld", valid_o, 0);
        check("r_dat", data_o, 0);
        check("r_msk", mask_o, 0);
        check("r_last", last_o, 0);
        check("r_rdy", ready_o, 1);
        check("r_fdone", flush_done_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
